// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ==== pong_game_ctrl : screen-flow, score and serve controller for pong ==== rev 1.0 ====
module pong_game_ctrl #(
    parameter int MAX_SCORE_INIT  = 5,
    parameter int MAX_SCORE_LIMIT = 20,
    parameter int POINT_HOLD      = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_launch,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       left_hit,
    input  logic       right_hit,
    output logic [2:0] state,
    output logic       state_entry,
    output logic [4:0] score_p1,
    output logic [4:0] score_p2,
    output logic [4:0] max_score,
    output logic [1:0] winner,
    output logic       serve_side
);

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_SET       = 3'd1,
        ST_START     = 3'd2,
        ST_PLAY      = 3'd3,
        ST_END_POINT = 3'd4,
        ST_END_GAME  = 3'd5
    } state_t;

    localparam logic [4:0] C_MAX_INIT  = 5'(MAX_SCORE_INIT);
    localparam logic [4:0] C_MAX_LIMIT = 5'(MAX_SCORE_LIMIT);
    localparam logic [7:0] C_HOLD_LAST = 8'(POINT_HOLD - 1);

    state_t     state_q, state_d;
    logic       state_entry_q, state_entry_d;
    logic [4:0] score_p1_q, score_p1_d;
    logic [4:0] score_p2_q, score_p2_d;
    logic [4:0] max_score_q, max_score_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_side_q, serve_side_d;
    logic [7:0] hold_q, hold_d;
    // Button vectors are ordered {down, up, launch}
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] samp_q, samp_d;
    logic [2:0] press;

    always_comb begin
        sync1_d = {btn_down, btn_up, btn_launch};
        sync2_d = sync1_q;
        samp_d  = frame_tick ? sync2_q : samp_q;
        press   = frame_tick ? (sync2_q & ~samp_q) : 3'b000;
    end

    always_comb begin
        state_d      = state_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        max_score_d  = max_score_q;
        winner_d     = winner_q;
        serve_side_d = serve_side_q;
        hold_d       = hold_q;

        case (state_q)
            ST_MENU: begin
                if (press[0]) begin
                    state_d    = ST_SET;
                    winner_d   = 2'd0;
                    score_p1_d = 5'd0;
                    score_p2_d = 5'd0;
                end
            end
            ST_SET: begin
                if (press[0]) begin
                    state_d = ST_START;
                end else if (press[1] && !press[2]) begin
                    if (max_score_q < C_MAX_LIMIT) max_score_d = max_score_q + 5'd1;
                end else if (press[2] && !press[1]) begin
                    if (max_score_q > 5'd1) max_score_d = max_score_q - 5'd1;
                end
            end
            ST_START: begin
                if (press[0]) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (left_hit || right_hit) begin
                    state_d = ST_END_POINT;
                    hold_d  = 8'd0;
                    // Simultaneous hits are treated as a replay: nobody scores
                    if (right_hit && !left_hit) begin
                        score_p1_d   = score_p1_q + 5'd1;
                        serve_side_d = 1'b1;
                    end else if (left_hit && !right_hit) begin
                        score_p2_d   = score_p2_q + 5'd1;
                        serve_side_d = 1'b0;
                    end
                end
            end
            ST_END_POINT: begin
                if (frame_tick) begin
                    if (hold_q == C_HOLD_LAST) begin
                        if (score_p1_q == max_score_q) begin
                            winner_d = 2'd1;
                            state_d  = ST_END_GAME;
                        end else if (score_p2_q == max_score_q) begin
                            winner_d = 2'd2;
                            state_d  = ST_END_GAME;
                        end else begin
                            state_d = ST_START;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            ST_END_GAME: begin
                if (press[0]) begin
                    state_d  = ST_MENU;
                    winner_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase

        state_entry_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_MENU;
            state_entry_q <= 1'b0;
            score_p1_q    <= 5'd0;
            score_p2_q    <= 5'd0;
            max_score_q   <= C_MAX_INIT;
            winner_q      <= 2'd0;
            serve_side_q  <= 1'b0;
            hold_q        <= 8'd0;
            sync1_q       <= 3'b000;
            sync2_q       <= 3'b000;
            samp_q        <= 3'b000;
        end else begin
            state_q       <= state_d;
            state_entry_q <= state_entry_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            max_score_q   <= max_score_d;
            winner_q      <= winner_d;
            serve_side_q  <= serve_side_d;
            hold_q        <= hold_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            samp_q        <= samp_d;
        end
    end

    assign state       = state_q;
    assign state_entry = state_entry_q;
    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign max_score   = max_score_q;
    assign winner      = winner_q;
    assign serve_side  = serve_side_q;

endmodule
`default_nettype wire
